// File: rtl/cic_interpolator.sv
// Three-stage CIC interpolator: takes one low-rate sample per R clocks and emits one sample every clk.
// Latency: a sample accepted at edge t first reaches data_out after edge t+5.
// Backpressure: none on the output. in_ready opens one cycle in R; a missed slot repeats the last sample and pulses underrun.
//
// Ports:
//   clk        system clock, equal to the output sample rate
//   reset_n    asynchronous active-low reset
//   os_sel     rate select, R = 2^(os_sel+1) (2..256); a change restarts the filter
//   data_in    signed low-rate input sample
//   in_valid   data_in valid (only looked at in slot cycles)
//   in_ready   block wants a sample this cycle (phase 0)
//   data_out   signed interpolated sample, registered, saturated to DW bits
//   out_valid  data_out carries filtered data
//   underrun   one-cycle pulse in a slot where no sample was offered
module cic_interpolator #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    os_sel,
    input  logic [DW-1:0] data_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          underrun
);

    // Accumulator width: three integrators of gain up to 256 each need 24 guard bits.
    localparam int W = DW + 24;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]    r_ph;          // phase within one low-rate period
    logic          r_started;     // set by the first accepted sample
    logic [2:0]    r_os;          // shadow of os_sel the filter is running with
    logic [W-1:0]  r_x;           // last accepted sample, sign-extended
    logic          r_ld;          // r_x must be pushed through the combs this cycle
    logic [W-1:0]  r_d0;
    logic [W-1:0]  r_d1;
    logic [W-1:0]  r_d2;
    logic [W-1:0]  r_up;          // zero-stuffed comb output
    logic [W-1:0]  r_i1;
    logic [W-1:0]  r_i2;
    logic [W-1:0]  r_i3;
    logic [4:0]    r_vsr;         // tracks how far the first sample has travelled
    logic          r_out_valid;
    logic [DW-1:0] r_data_out;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [7:0]    w_mask;
    logic [7:0]    w_ph_nxt;
    logic          w_restart;
    logic          w_ph_zero;
    logic          w_accept;
    logic          w_slot;
    logic          w_underrun;
    logic          w_run;

    // R-1 as a bit mask; R is always a power of two so wrapping is a mask.
    assign w_mask     = 8'hFF >> (3'd7 - r_os);

    // Any difference between the live select and the shadow restarts the
    // filter on the next edge; it takes priority over a sample in the same cycle.
    assign w_restart  = (os_sel != r_os);

    assign w_ph_zero  = (r_ph == 8'd0);
    assign w_accept   = in_valid & w_ph_zero & ~w_restart;
    assign w_slot     = w_ph_zero & r_started;
    assign w_underrun = w_slot & ~in_valid & ~w_restart;

    // The phase starts moving on the edge that takes the first sample.
    assign w_run      = r_started | w_accept;
    assign w_ph_nxt   = w_run ? ((r_ph + 8'd1) & w_mask) : 8'd0;

    assign in_ready   = reset_n & w_ph_zero;
    assign underrun   = w_underrun;

    // ------------------------------------------------------------------
    // Phase, start flag and rate shadow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ph      <= 8'd0;
            r_started <= 1'b0;
            r_os      <= 3'd0;
        end else if (w_restart) begin
            r_ph      <= 8'd0;
            r_started <= 1'b0;
            r_os      <= os_sel;
        end else begin
            r_ph      <= w_ph_nxt;
            if (w_accept) begin
                r_started <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb section (low rate) and zero-stuffing
    // ------------------------------------------------------------------
    logic [W-1:0] w_x_ext;
    logic [W-1:0] w_c0;
    logic [W-1:0] w_c1;
    logic [W-1:0] w_c2;
    logic [W-1:0] w_c3;

    assign w_x_ext = {{(W-DW){data_in[DW-1]}}, data_in};

    // The sample is registered first so the subtractor chain starts at a flop.
    assign w_c0 = r_x;
    assign w_c1 = w_c0 - r_d0;
    assign w_c2 = w_c1 - r_d1;
    assign w_c3 = w_c2 - r_d2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x  <= '0;
            r_ld <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_up <= '0;
        end else if (w_restart) begin
            r_x  <= '0;
            r_ld <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_up <= '0;
        end else begin
            // An underrun slot leaves r_x alone, so the previous sample repeats.
            r_ld <= w_accept | w_underrun;
            if (w_accept) begin
                r_x <= w_x_ext;
            end
            if (r_ld) begin
                r_d0 <= w_c0;
                r_d1 <= w_c1;
                r_d2 <= w_c2;
                r_up <= w_c3;
            end else begin
                r_up <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Integrators (high rate). Wrap-around is part of how a CIC works:
    // the combs cancel the overflow, so these must stay plain modular adders.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
        end else if (w_restart) begin
            r_i1 <= '0;
            r_i2 <= '0;
            r_i3 <= '0;
        end else begin
            r_i1 <= r_i1 + r_up;
            r_i2 <= r_i2 + r_i1;
            r_i3 <= r_i3 + r_i2;
        end
    end

    // ------------------------------------------------------------------
    // Output scaling and saturation
    // ------------------------------------------------------------------
    logic [4:0]    w_shift;
    logic [W-1:0]  w_sh;
    logic [W-DW:0] w_top;
    logic          w_fits;
    logic [DW-1:0] w_sat;

    // DC gain of the filter is R^2, so shifting by 2*log2(R) normalises it.
    assign w_shift = {1'b0, r_os, 1'b0} + 5'd2;
    assign w_sh    = $signed(r_i3) >>> w_shift;

    // The value fits in DW bits when every bit above the DW-1 sign bit matches it.
    assign w_top   = w_sh[W-1:DW-1];
    assign w_fits  = (&w_top) | ~(|w_top);

    always_comb begin
        w_sat = w_sh[DW-1:0];
        if (!w_fits) begin
            w_sat = w_sh[W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out  <= '0;
            r_vsr       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_restart) begin
            r_data_out  <= '0;
            r_vsr       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_data_out  <= w_sat;
            // w_run stays high once started, so out_valid holds until reset/restart.
            r_vsr       <= {r_vsr[3:0], w_run};
            r_out_valid <= r_vsr[4];
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cic_interpolator.sv
module tb_cic_interpolator;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    os_sel;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          underrun;

    always #5 clk = ~clk;

    cic_interpolator #(.DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .os_sel   (os_sel),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .out_valid(out_valid),
        .underrun (underrun)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: CIC = FIR with taps box(R)*box(R)*box(R) applied to
    // the zero-stuffed (or repeated-on-underrun) input, then >>> 2*log2(R).
    // ------------------------------------------------------------------
    int     m_os;
    int     m_R;
    int     m_S;
    int     m_ph;
    bit     m_started;
    longint m_last;
    int     pushes;
    longint h[$];
    longint xup[$];
    longint expq[$];
    longint obs[$];
    int     n_under_seen;
    int     n_rdy_seen;

    function automatic void set_rate(input int os);
        longint t[$];
        longint s;
        m_os = os;
        m_R  = 1 << (os + 1);
        m_S  = 2 * (os + 1);
        h.delete();
        for (int i = 0; i < m_R; i++) h.push_back(1);
        for (int p = 0; p < 2; p++) begin
            t.delete();
            for (int i = 0; i < int'(h.size()) + m_R - 1; i++) begin
                s = 0;
                for (int j = 0; j < m_R; j++)
                    if (i - j >= 0 && i - j < int'(h.size())) s += h[i-j];
                t.push_back(s);
            end
            h = t;
        end
    endfunction

    function automatic void model_clear();
        m_started = 0;
        m_ph      = 0;
        m_last    = 0;
        pushes    = 0;
        xup.delete();
        expq.delete();
    endfunction

    function automatic longint y_of(input int n);
        longint s;
        longint q;
        longint smax;
        s = 0;
        for (int k = 0; k < int'(h.size()) && k <= n; k++) s += h[k] * xup[n-k];
        q    = s >>> m_S;
        smax = (longint'(1) << (DW - 1)) - 1;
        if (q > smax) q = smax;
        else if (q < -smax - 1) q = -smax - 1;
        return q;
    endfunction

    // Count logged outputs from index 'from' on that differ from v.
    function automatic int obs_bad(input int from, input longint v);
        int bad;
        bad = 0;
        if (int'(obs.size()) <= from) return 1;
        for (int i = from; i < int'(obs.size()); i++) if (obs[i] != v) bad++;
        return bad;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, predict,
    // advance the clock, then check the registered outputs.
    task automatic cyc(input bit v, input int d);
        bit     restart;
        bit     rdy;
        bit     acc;
        bit     und;
        bit     ev;
        longint xv;
        longint e;
        in_valid = v;
        data_in  = d[DW-1:0];
        #1;
        restart = (int'(os_sel) != m_os);
        rdy     = (m_ph == 0);
        acc     = v && rdy && !restart;
        und     = rdy && m_started && !v && !restart;
        check("in_ready", in_ready, rdy);
        check("underrun", underrun, und);
        if (underrun) n_under_seen++;
        if (in_ready) n_rdy_seen++;
        if (!restart && (m_started || acc)) begin
            xv = 0;
            if (acc) begin
                m_last = d;
                xv     = d;
            end else if (und) begin
                xv = m_last;
            end
            xup.push_back(xv);
            expq.push_back(y_of(int'(xup.size()) - 1));
            pushes++;
            m_ph      = (m_ph + 1) % m_R;
            m_started = 1;
        end
        @(posedge clk);
        #1;
        if (restart) begin
            set_rate(int'(os_sel));
            model_clear();
        end
        ev = (pushes >= 6);
        check("out_valid", out_valid, ev);
        if (ev) begin
            e = expq.pop_front();
            check("data_out", $signed(data_out), e);
            obs.push_back(longint'($signed(data_out)));
        end else begin
            check("data_out_idle", $signed(data_out), 0);
        end
    endtask

    int imp_exp[5] = '{256, 768, 768, 256, 0};
    bit flip;

    initial begin
        reset_n  = 1'b0;
        os_sel   = 3'd0;
        in_valid = 1'b0;
        data_in  = '0;
        set_rate(0);
        model_clear();
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_underrun", underrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Impulse at R=2
        obs.delete();
        cyc(1, 1024);
        for (int i = 0; i < 20; i++) cyc(1, 0);
        for (int i = 0; i < 5; i++) check("impulse_shape", obs[i], imp_exp[i]);

        // DC 1000 at R=2
        obs.delete();
        for (int i = 0; i < 30; i++) cyc(1, 1000);
        check("dc1000_settle", obs_bad(8, 1000), 0);
        check("dc1000_final", $signed(data_out), 1000);

        // Switch to R=4 (sample offered in the restart cycle is dropped), then underrun
        os_sel = 3'd1;
        cyc(1, 777);
        for (int i = 0; i < 40; i++) cyc(1, 500);
        obs.delete();
        n_under_seen = 0;
        while (m_ph != 0) cyc(1, 500);
        cyc(0, 500);
        for (int i = 0; i < 20; i++) cyc(1, 500);
        check("underrun_pulses", n_under_seen, 1);
        check("underrun_hold", obs_bad(0, 500), 0);

        // Restart 1 -> 2 mid-run, R=8
        os_sel = 3'd2;
        cyc(1, 300);
        check("restart_vld_drop", out_valid, 0);
        for (int i = 0; i < 100; i++) cyc(1, 300);
        check("r8_final", $signed(data_out), 300);

        // Full-scale alternation at R=2
        os_sel = 3'd0;
        cyc(1, 0);
        flip = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_ph == 0 && m_started) flip = ~flip;
            cyc(1, flip ? -32768 : 32767);
        end

        // DC -20000 at R=256
        os_sel = 3'd7;
        cyc(1, 0);
        for (int i = 0; i < 1600; i++) cyc(1, -20000);
        obs.delete();
        n_rdy_seen = 0;
        for (int i = 0; i < 512; i++) cyc(1, -20000);
        check("r256_ready_count", n_rdy_seen, 2);
        check("r256_settle", obs_bad(0, -20000), 0);
        check("r256_final", $signed(data_out), -20000);

        // Asynchronous reset mid-stream
        reset_n = 1'b0;
        #2;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_underrun", underrun, 0);
        os_sel   = 3'd0;
        in_valid = 1'b0;
        set_rate(0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        obs.delete();
        cyc(1, 1024);
        for (int i = 0; i < 12; i++) cyc(1, 0);
        for (int i = 0; i < 4; i++) check("impulse_after_reset", obs[i], imp_exp[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

endmodule
